store_buf: RTL and testbench

STORE_BUF -- requirements
Module: store_buf

---
 rtl/store_buf.sv | 115 +++++++++++
 tb/tb_store_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buf.sv
// Store buffer between the core and data memory.
// Stores enter a circular FIFO and drain to memory in program order. Loads
// get zero-latency forwarding from the youngest buffered store to the same
// word address, and otherwise see memory read data.
//
// Drain handshake: o_mem_we is the valid and i_mem_ready is the ready. The
// head entry retires on a rising edge where both are high. While o_mem_we is
// high, the head address and data stay stable until that edge.
module store_buf #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  output logic             o_stall,
  output logic             o_empty,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_waddr,
  output logic [31:0]      o_mem_wdata,
  output logic [WIDTH-1:0] o_mem_raddr,
  input  logic [31:0]      i_mem_rdata,
  input  logic             i_mem_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             full;
  logic             drain;
  logic             accept;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PW-1:0]    idx;

  // A full buffer can still take a store in the cycle its head drains.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    o_mem_we    = (count_q != '0);
    drain       = o_mem_we && i_mem_ready;
    accept      = i_we && (!full || drain);
    o_stall     = i_we && full && !drain;
    o_empty     = (count_q == '0);
    o_mem_waddr = addr_q[head_q];
    o_mem_wdata = data_q[head_q];
    o_mem_raddr = i_addr;
  end

  // Walk from oldest to youngest so that the last match is the youngest.
  // The draining head is still valid here, so it forwards until the edge.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx] == i_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // Forward only to loads. The store presented this cycle is not yet in the buffer.
  always_comb begin
    o_data = i_mem_rdata;
    if (!i_we && fwd_hit) begin
      o_data = fwd_data;
    end
  end

  // Pointers, occupancy and valids. Reset discards everything at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      // The accept assignment comes last so it wins when head and tail share a slot.
      if (accept) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({accept, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload storage. The valid bits above give it meaning, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q[tail_q] <= i_addr;
      data_q[tail_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_store_buf.sv
// Directed bench for store_buf. Memory read data is a fixed function of the
// read address, 0xD0000000 | addr. The bench records every write that
// memory accepts.
module tb_store_buf;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             stall;
  logic             empty;
  logic             mem_we;
  logic [WIDTH-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [WIDTH-1:0] mem_raddr;
  logic [31:0]      mem_rdata;
  logic             mem_ready;

  int checks = 0;
  int errors = 0;

  logic [WIDTH+31:0] got_q[$];
  logic [WIDTH+31:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  store_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_we        (we),
    .i_addr      (addr),
    .i_data      (wdata),
    .o_data      (rdata),
    .o_stall     (stall),
    .o_empty     (empty),
    .o_mem_we    (mem_we),
    .o_mem_waddr (mem_waddr),
    .o_mem_wdata (mem_wdata),
    .o_mem_raddr (mem_raddr),
    .i_mem_rdata (mem_rdata),
    .i_mem_ready (mem_ready)
  );

  assign mem_rdata = {20'hD0000, mem_raddr};

  // Memory model: log each accepted drain write
  always @(posedge clk) begin
    if (mem_we && mem_ready) got_q.push_back({mem_waddr, mem_wdata});
  end

  // Driver tasks
  task automatic drv_store(input logic [WIDTH-1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
  endtask

  task automatic drv_idle();
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; addr = '0; wdata = '0; mem_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    repeat (2) @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    // Three stores held pending, then an asynchronous reset between edges
    got_q.delete();
    drv_store(12'h0A1, 32'hA1);
    drv_store(12'h0A2, 32'hA2);
    drv_store(12'h0A3, 32'hA3);
    drv_idle();
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pend_mem_we: got %b exp 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_async_mem_we: got %b exp 0", mem_we); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b exp 1", empty); end
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_no_writes: got %0d writes exp 0", got_q.size()); end
    mem_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    got_q.delete(); exp_q.delete();
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drv_store(WIDTH'(i), 32'h1000 + i);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b exp 0", i, stall); end
      exp_q.push_back({WIDTH'(i), 32'h1000 + i});
    end
    exp_q.push_back({WIDTH'(5), 32'h1005});
    drv_store(WIDTH'(5), 32'h1005);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b exp 1", stall); end
    @(negedge clk);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL held_stall: got %b exp 1", stall); end
    checks++; if (mem_waddr !== WIDTH'(1)) begin errors++; $display("FAIL held_head: got %h exp 001", mem_waddr); end
    mem_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_unstall: got %b exp 0", stall); end
    drv_idle();
    for (int c = 0; c < 20 && !empty; c++) @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drain_timeout: got empty=%b exp 1", empty); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_order_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_forward();
    got_q.delete(); exp_q.delete();
    mem_ready = 1'b0;
    drv_store(12'h007, 32'hAAAA);
    drv_store(12'h007, 32'hBBBB);
    @(negedge clk);
    we = 1'b0; addr = 12'h007;
    #1;
    checks++; if (rdata !== 32'hBBBB) begin errors++; $display("FAIL fwd_youngest: got %h exp 0000bbbb", rdata); end
    checks++; if (mem_raddr !== 12'h007) begin errors++; $display("FAIL fwd_raddr: got %h exp 007", mem_raddr); end
    addr = 12'h008;
    #1;
    checks++; if (rdata !== 32'hD0000008) begin errors++; $display("FAIL fwd_miss: got %h exp d0000008", rdata); end
    // A store to a buffered address: o_data follows memory, not the buffer
    we = 1'b1; addr = 12'h007; wdata = 32'hCCCC;
    #1;
    checks++; if (rdata !== 32'hD0000007) begin errors++; $display("FAIL store_odata: got %h exp d0000007", rdata); end
    @(negedge clk);
    we = 1'b0; addr = 12'h007;
    #1;
    checks++; if (rdata !== 32'hCCCC) begin errors++; $display("FAIL fwd_third: got %h exp 0000cccc", rdata); end
    exp_q.push_back({12'h007, 32'hAAAA});
    exp_q.push_back({12'h007, 32'hBBBB});
    exp_q.push_back({12'h007, 32'hCCCC});
    mem_ready = 1'b1;
    for (int c = 0; c < 20 && !empty; c++) @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fwd_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fwd_order_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_same_cycle();
    got_q.delete(); exp_q.delete();
    mem_ready = 1'b0;
    drv_store(12'h014, 32'h2020);
    drv_store(12'h015, 32'h2121);
    // count=2: a store and a drain on the same edge
    @(negedge clk);
    we = 1'b1; addr = 12'h016; wdata = 32'h2222; mem_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b exp 0", stall); end
    checks++; if (mem_waddr !== 12'h014) begin errors++; $display("FAIL same_head: got %h exp 014", mem_waddr); end
    // Load the address that is draining this cycle
    @(negedge clk);
    we = 1'b0; addr = 12'h015;
    #1;
    checks++; if (rdata !== 32'h2121) begin errors++; $display("FAIL drain_fwd: got %h exp 00002121", rdata); end
    checks++; if (mem_waddr !== 12'h015) begin errors++; $display("FAIL drain_head: got %h exp 015", mem_waddr); end
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL same_count_left: got empty=%b exp 0", empty); end
    checks++; if (rdata !== 32'hD0000015) begin errors++; $display("FAIL after_retire: got %h exp d0000015", rdata); end
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL same_count_end: got empty=%b exp 1", empty); end
    mem_ready = 1'b0;
    exp_q.push_back({12'h014, 32'h2020});
    exp_q.push_back({12'h015, 32'h2121});
    exp_q.push_back({12'h016, 32'h2222});
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL same_wcount: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL same_order_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    int k;
    int c;
    got_q.delete(); exp_q.delete();
    mem_ready = 1'b0;
    k = 0; c = 0;
    while (k < 10 && c < 100) begin
      @(negedge clk);
      mem_ready = ~mem_ready;
      we = 1'b1; addr = WIDTH'(40 + k); wdata = 32'h4000 + k;
      #1;
      if (!stall) begin
        exp_q.push_back({WIDTH'(40 + k), 32'h4000 + k});
        k++;
      end
      c++;
    end
    checks++; if (k != 10) begin errors++; $display("FAIL wrap_accept: got %0d stores exp 10", k); end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 40 && !empty; i++) begin
      @(negedge clk);
      mem_ready = ~mem_ready;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_timeout: got empty=%b exp 1", empty); end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d exp 10", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_empty();
    @(negedge clk);
    we = 1'b0; addr = 12'h003; mem_ready = 1'b0;
    #1;
    checks++; if (rdata !== 32'hD0000003) begin errors++; $display("FAIL empty_load: got %h exp d0000003", rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL empty_mem_we: got %b exp 0", mem_we); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_flag: got %b exp 1", empty); end
    checks++; if (mem_raddr !== 12'h003) begin errors++; $display("FAIL empty_raddr: got %h exp 003", mem_raddr); end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_forward();
    test_same_cycle();
    test_wrap();
    test_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
